// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches over a request/response
// memory port and buffers the returned words with their PCs in a small FIFO for decode.
module fetch_queue #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_resp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [31:0]   fetch_pc_r, resp_pc_r;
    logic [CW-1:0] count_r, inflight_r, discard_r;
    logic [PW-1:0] wptr_r, rptr_r;
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   inst_mem_r [DEPTH];

    logic          req_fire_s, deq_fire_s, resp_keep_s, resp_drop_s;
    logic [CW:0]   credit_s;
    logic [CW-1:0] count_nxt_s, inflight_nxt_s, discard_nxt_s;
    logic          unused_s;

    assign unused_s = ^i_redirect_pc[1:0];

    // Handshake outputs and the per-cycle event decode.
    always_comb begin
        credit_s        = {1'b0, count_r} + {1'b0, inflight_r};
        o_mem_req_valid = !i_rst && !i_redirect_valid && (credit_s < DEPTH_W);
        o_mem_req_addr  = fetch_pc_r;
        o_inst_valid    = !i_rst && !i_redirect_valid && (count_r != ZERO_C);
        o_inst          = inst_mem_r[rptr_r];
        o_inst_pc       = pc_mem_r[rptr_r];
        req_fire_s      = o_mem_req_valid && i_mem_req_ready;
        deq_fire_s      = o_inst_valid && i_inst_ready;
        resp_drop_s     = i_mem_resp_valid && (discard_r != ZERO_C);
        resp_keep_s     = i_mem_resp_valid && (discard_r == ZERO_C) && !i_redirect_valid;
    end

    // Next values of the occupancy, in-flight and stale-response counters.
    always_comb begin
        inflight_nxt_s = inflight_r;
        count_nxt_s    = count_r;
        discard_nxt_s  = discard_r;
        if (req_fire_s && !i_mem_resp_valid) begin
            inflight_nxt_s = inflight_r + ONE_C;
        end else if (!req_fire_s && i_mem_resp_valid) begin
            inflight_nxt_s = inflight_r - ONE_C;
        end else begin
            inflight_nxt_s = inflight_r;
        end
        // Every request still outstanding at a redirect belongs to the old path.
        if (i_redirect_valid) begin
            count_nxt_s   = ZERO_C;
            discard_nxt_s = i_mem_resp_valid ? (inflight_r - ONE_C) : inflight_r;
        end else begin
            if (resp_keep_s && !deq_fire_s) begin
                count_nxt_s = count_r + ONE_C;
            end else if (!resp_keep_s && deq_fire_s) begin
                count_nxt_s = count_r - ONE_C;
            end else begin
                count_nxt_s = count_r;
            end
            if (resp_drop_s) begin
                discard_nxt_s = discard_r - ONE_C;
            end else begin
                discard_nxt_s = discard_r;
            end
        end
    end

    // Control state: PCs, counters and FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_r <= {RESET_ADDR[31:2], 2'b00};
            resp_pc_r  <= {RESET_ADDR[31:2], 2'b00};
            count_r    <= ZERO_C;
            inflight_r <= ZERO_C;
            discard_r  <= ZERO_C;
            wptr_r     <= {PW{1'b0}};
            rptr_r     <= {PW{1'b0}};
        end else begin
            count_r    <= count_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= discard_nxt_s;
            if (i_redirect_valid) begin
                fetch_pc_r <= {i_redirect_pc[31:2], 2'b00};
                resp_pc_r  <= {i_redirect_pc[31:2], 2'b00};
                rptr_r     <= wptr_r;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd4;
                end
                if (resp_keep_s) begin
                    wptr_r    <= wptr_r + PONE_C;
                    resp_pc_r <= resp_pc_r + 32'd4;
                end
                if (deq_fire_s) begin
                    rptr_r <= rptr_r + PONE_C;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (resp_keep_s) begin
            pc_mem_r[wptr_r]   <= resp_pc_r;
            inst_mem_r[wptr_r] <= i_mem_resp_data;
        end
    end

    fetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_mem_resp_valid(i_mem_resp_valid),
        .count           (count_r),
        .inflight        (inflight_r)
    );
endmodule

// Protocol checks: responses only for outstanding requests, never into a full FIFO.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          i_clk,
    input logic          i_rst,
    input logic          i_mem_resp_valid,
    input logic [CW-1:0] count,
    input logic [CW-1:0] inflight
);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        i_mem_resp_valid |-> ({1'b0, count} < DEPTH_W));
    a_resp_expected: assert property (@(posedge i_clk) disable iff (i_rst)
        i_mem_resp_valid |-> (inflight != {CW{1'b0}}));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vectors for fetch_queue: each record drives one cycle of inputs (including
// hand-scheduled memory responses) and holds the hand-computed outputs for that cycle.
module tb_fetch_queue;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    typedef struct {
        bit          dut;      // 0: RESET_ADDR=0 instance, 1: RESET_ADDR=0x80 instance
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] ra;       // address whose word is returned when rv=1
        bit          ir;
        bit          rd;
        logic [31:0] rpc;
        bit          e_rqv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst0, rst80;
    logic        req_ready, resp_valid, inst_ready, redir_valid;
    logic [31:0] resp_data, redir_pc;
    logic        rqv0, rqv80, iv0, iv80;
    logic [31:0] raddr0, raddr80, inst0, inst80, ipc0, ipc80;

    int total = 0;
    int bad   = 0;
    int step  = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    fetch_queue #(.RESET_ADDR(32'h0000_0000), .DEPTH(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst0),
        .o_mem_req_valid(rqv0), .i_mem_req_ready(req_ready), .o_mem_req_addr(raddr0),
        .i_mem_resp_valid(resp_valid), .i_mem_resp_data(resp_data),
        .o_inst_valid(iv0), .i_inst_ready(inst_ready), .o_inst(inst0), .o_inst_pc(ipc0),
        .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc)
    );

    fetch_queue #(.RESET_ADDR(32'h0000_0080), .DEPTH(4)) u_dut80 (
        .i_clk(clk), .i_rst(rst80),
        .o_mem_req_valid(rqv80), .i_mem_req_ready(req_ready), .o_mem_req_addr(raddr80),
        .i_mem_resp_valid(resp_valid), .i_mem_resp_data(resp_data),
        .o_inst_valid(iv80), .i_inst_ready(inst_ready), .o_inst(inst80), .o_inst_pc(ipc80),
        .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc)
    );

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic vec_t mk(input bit dut, input bit rst, input bit rdy, input bit rv,
                                input logic [31:0] ra, input bit ir, input bit rd,
                                input logic [31:0] rpc, input bit e_rqv,
                                input logic [31:0] e_addr, input bit e_iv,
                                input logic [31:0] e_pc);
        vec_t v;
        v.dut = dut; v.rst = rst; v.rdy = rdy; v.rv = rv; v.ra = ra; v.ir = ir;
        v.rd = rd; v.rpc = rpc; v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, step, act, exp);
        end
    endtask

    // Drive one cycle just after the edge, check mid-cycle, then advance past the next edge.
    task automatic run(input vec_t v);
        rst0        = v.dut ? 1'b1 : v.rst;
        rst80       = v.dut ? v.rst : 1'b1;
        req_ready   = v.rdy;
        resp_valid  = v.rv;
        resp_data   = v.rv ? word_at(v.ra) : 32'h0000_0000;
        inst_ready  = v.ir;
        redir_valid = v.rd;
        redir_pc    = v.rpc;
        #3;
        chk("req_valid", {31'd0, v.dut ? rqv80 : rqv0}, {31'd0, v.e_rqv});
        if (v.e_rqv) chk("req_addr", v.dut ? raddr80 : raddr0, v.e_addr);
        chk("inst_valid", {31'd0, v.dut ? iv80 : iv0}, {31'd0, v.e_iv});
        if (v.e_iv) begin
            chk("inst_pc", v.dut ? ipc80 : ipc0, v.e_pc);
            chk("inst", v.dut ? inst80 : inst0, word_at(v.e_pc));
        end
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst80 = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0;
        inst_ready = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
        @(posedge clk);
        #1;

        // Latency 1, ready high, decode always ready.
        vq.push_back(mk(L,H,H,L,32'h0,H,L,32'h0, L,32'h0,L,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h0,L,32'h0));
        vq.push_back(mk(L,L,H,H,32'h0,H,L,32'h0, H,32'h4,L,32'h0));
        vq.push_back(mk(L,L,H,H,32'h4,H,L,32'h0, H,32'h8,H,32'h0));
        vq.push_back(mk(L,L,H,H,32'h8,H,L,32'h0, H,32'hC,H,32'h4));
        vq.push_back(mk(L,L,L,H,32'hC,H,L,32'h0, H,32'h10,H,32'h8));
        vq.push_back(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h10,H,32'hC));
        vq.push_back(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h10,L,32'h0));
        // Decode stalled: four requests then credit exhausted; release resumes at 0x10.
        vq.push_back(mk(L,H,H,L,32'h0,L,L,32'h0, L,32'h0,L,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,L,L,32'h0, H,32'h0,L,32'h0));
        vq.push_back(mk(L,L,H,H,32'h0,L,L,32'h0, H,32'h4,L,32'h0));
        vq.push_back(mk(L,L,H,H,32'h4,L,L,32'h0, H,32'h8,H,32'h0));
        vq.push_back(mk(L,L,H,H,32'h8,L,L,32'h0, H,32'hC,H,32'h0));
        vq.push_back(mk(L,L,H,H,32'hC,L,L,32'h0, L,32'h0,H,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,L,L,32'h0, L,32'h0,H,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,H,L,32'h0, L,32'h0,H,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h10,H,32'h4));
        vq.push_back(mk(L,L,H,H,32'h10,L,L,32'h0, H,32'h14,H,32'h8));
        // Request ready toggling 1,0,0,1: no skipped or repeated PCs.
        vq.push_back(mk(L,H,H,L,32'h0,L,L,32'h0, L,32'h0,L,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,L,L,32'h0, H,32'h0,L,32'h0));
        vq.push_back(mk(L,L,L,H,32'h0,L,L,32'h0, H,32'h4,L,32'h0));
        vq.push_back(mk(L,L,L,L,32'h0,L,L,32'h0, H,32'h4,H,32'h0));
        vq.push_back(mk(L,L,H,L,32'h0,L,L,32'h0, H,32'h4,H,32'h0));
        vq.push_back(mk(L,L,L,H,32'h4,L,L,32'h0, H,32'h8,H,32'h0));
        vq.push_back(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h8,H,32'h0));
        vq.push_back(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h8,H,32'h4));
        vq.push_back(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h8,L,32'h0));
        foreach (vq[i]) run(vq[i]);

        // PC wrap past 0xFFFFFFFC.
        run(mk(L,L,H,L,32'h0,H,H,32'hFFFF_FFFC, L,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'hFFFF_FFFC,L,32'h0));
        run(mk(L,L,H,H,32'hFFFF_FFFC,H,L,32'h0, H,32'h0,L,32'h0));
        run(mk(L,L,H,H,32'h0,H,L,32'h0, H,32'h4,H,32'hFFFF_FFFC));
        run(mk(L,L,L,H,32'h4,H,L,32'h0, H,32'h8,H,32'h0));
        // Back-to-back redirects with a queued entry: last wins, FIFO flushed.
        run(mk(L,L,H,L,32'h0,H,H,32'h300, L,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,H,32'h404, L,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h404,L,32'h0));
        run(mk(L,L,L,H,32'h404,H,L,32'h0, H,32'h408,L,32'h0));
        run(mk(L,L,L,L,32'h0,H,L,32'h0, H,32'h408,H,32'h404));

        // Latency 3: redirect to 0x100 with two requests in flight.
        run(mk(L,H,H,L,32'h0,H,L,32'h0, L,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h4,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,H,32'h100, L,32'h0,L,32'h0));
        run(mk(L,L,H,H,32'h0,H,L,32'h0, H,32'h100,L,32'h0));
        run(mk(L,L,H,H,32'h4,H,L,32'h0, H,32'h104,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h108,L,32'h0));
        run(mk(L,L,H,H,32'h100,H,L,32'h0, H,32'h10C,L,32'h0));
        run(mk(L,L,H,H,32'h104,H,L,32'h0, L,32'h0,H,32'h100));
        run(mk(L,L,H,H,32'h108,H,L,32'h0, H,32'h110,H,32'h104));

        // Latency 2: response coincident with redirect to 0x202 is dropped, one more stale.
        run(mk(L,H,H,L,32'h0,L,L,32'h0, L,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,L,L,32'h0, H,32'h0,L,32'h0));
        run(mk(L,L,H,L,32'h0,L,L,32'h0, H,32'h4,L,32'h0));
        run(mk(L,L,H,H,32'h0,H,H,32'h202, L,32'h0,L,32'h0));
        run(mk(L,L,H,H,32'h4,H,L,32'h0, H,32'h200,L,32'h0));
        run(mk(L,L,H,L,32'h0,H,L,32'h0, H,32'h204,L,32'h0));
        run(mk(L,L,H,H,32'h200,H,L,32'h0, H,32'h208,L,32'h0));
        run(mk(L,L,L,H,32'h204,H,L,32'h0, H,32'h20C,H,32'h200));

        // RESET_ADDR=0x80 instance, latency 2: reset with two in flight, memory flushed too.
        run(mk(H,H,H,L,32'h0,H,L,32'h0, L,32'h0,L,32'h0));
        run(mk(H,L,H,L,32'h0,H,L,32'h0, H,32'h80,L,32'h0));
        run(mk(H,L,H,L,32'h0,H,L,32'h0, H,32'h84,L,32'h0));
        run(mk(H,H,H,H,32'h80,H,L,32'h0, L,32'h0,L,32'h0));
        run(mk(H,L,H,L,32'h0,H,L,32'h0, H,32'h80,L,32'h0));
        run(mk(H,L,H,L,32'h0,H,L,32'h0, H,32'h84,L,32'h0));
        run(mk(H,L,H,H,32'h80,H,L,32'h0, H,32'h88,L,32'h0));
        run(mk(H,L,H,H,32'h84,H,L,32'h0, H,32'h8C,H,32'h80));
        run(mk(H,L,L,H,32'h88,L,L,32'h0, H,32'h90,H,32'h84));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front end that replaces the combinational imem port with a request/response memory interface of variable latency. It generates sequential fetch addresses and tracks in-flight requests. Returned instruction words are buffered with their PCs in a small FIFO and presented to the hart decode stage through a valid/ready handshake. A redirect input (taken branch, jump or trap) flushes the FIFO and silently discards responses still in flight.

Parameters:
RESET_ADDR, 32'h00000000, first fetch PC after reset
DEPTH, 4, FIFO entries and max (queued + in-flight) requests; power of 2, >= 2

Ports:
i_clk  input  1  global clock
i_rst  input  1  synchronous active-high reset
o_mem_req_valid  output  1  fetch request valid
i_mem_req_ready  input  1  memory accepts request this cycle
o_mem_req_addr  output  32  word-aligned fetch address
i_mem_resp_valid  input  1  response word valid (in order, >= 1 cycle after acceptance)
i_mem_resp_data  input  32  instruction word
o_inst_valid  output  1  FIFO head valid to decode
i_inst_ready  input  1  decode consumes head this cycle
o_inst  output  32  head instruction word
o_inst_pc  output  32  PC of head instruction
i_redirect_valid  input  1  redirect/flush this cycle
i_redirect_pc  input  32  new fetch PC

Behaviour:
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of the next non-stale response.
  - count: FIFO occupancy, 0..DEPTH.
  - inflight: accepted requests not yet answered, 0..DEPTH.
  - discard: stale responses still to drop, 0..DEPTH.
  - FIFO storage: {pc, inst} x DEPTH, with read/write pointers that wrap mod DEPTH.
- Reset (registered, takes effect next edge): fetch_pc = resp_pc = RESET_ADDR, all counters and pointers 0. During and after reset, o_inst_valid = 0 and o_mem_req_valid = 0 until the first non-reset cycle. FIFO data is don't-care.
- Request issue:
  - o_mem_req_valid = !i_rst & !i_redirect_valid & (count + inflight < DEPTH).
  - o_mem_req_addr = {fetch_pc[31:2], 2'b00}.
  - Accept = valid & ready: fetch_pc += 4, inflight += 1.
  - Valid may drop without a handshake; memory samples only on valid & ready.
- Response:
  - Every i_mem_resp_valid decrements inflight.
  - If discard > 0: decrement discard and drop the word.
  - Otherwise: write {resp_pc, data} at wptr, count += 1, resp_pc += 4.
  - A response is never written to the FIFO in the same cycle it is consumed by decode. There is no bypass, so minimum latency is request accepted at N, response at N+1, o_inst_valid at N+2.
- Dequeue:
  - o_inst_valid = (count != 0) & !i_redirect_valid.
  - o_inst and o_inst_pc come from the entry at rptr.
  - Fire = o_inst_valid & i_inst_ready: rptr += 1, count -= 1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- The credit rule count + inflight <= DEPTH makes overflow impossible. A response arriving when count == DEPTH is an assertion failure.
- Redirect (highest priority after reset):
  - fetch_pc = resp_pc = {i_redirect_pc[31:2], 2'b00}.
  - count = 0 and rptr = wptr.
  - discard = inflight - (i_mem_resp_valid ? 1 : 0).
  - inflight updated as normal.
  - A response arriving in the redirect cycle is dropped.
  - No request is issued and no dequeue happens that cycle.
- Redirect while discard > 0: same formula. discard then covers all in-flight requests, which are all stale.
- Back-to-back redirects: the last one wins. The first request to the new PC goes out the cycle after the redirect.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFC + 4 wraps to 0.

Test Plan:
- Reset, memory latency 1, ready always high, i_inst_ready = 1 -> requests 0x0, 0x4, 0x8 on consecutive cycles; first o_inst_valid two cycles after the first accept; o_inst_pc sequence 0x0, 0x4, 0x8 with the matching data.
- i_inst_ready = 0 with DEPTH = 4 -> exactly 4 requests accepted, then o_mem_req_valid = 0; count = 4; releasing ready resumes with a request to 0x10.
- Memory latency 3, redirect to 0x100 with inflight = 2 -> both stale responses dropped; next o_inst_pc = 0x100; no 0x8/0xC entries appear.
- Response coincident with redirect to 0x202 -> that word dropped; discard = inflight - 1; next request address 0x200.
- i_mem_req_ready toggling 1,0,0,1 -> fetch_pc advances only on handshakes; no skipped or duplicated PCs.
- i_rst asserted mid-stream with 2 in flight, RESET_ADDR = 0x80 -> outputs deasserted; first post-reset request to 0x80.
